// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory server.
package imem_pkg;

  localparam int IMEM_DEPTH   = 64;
  localparam int IMEM_AW      = 6;
  localparam int IMEM_DW      = 32;
  localparam int IMEM_LAT_MIN = 1;
  localparam int IMEM_LAT_MAX = 4;
  // Wide enough to hold LATENCY-1 for the largest legal latency.
  localparam int IMEM_CW      = $clog2(IMEM_LAT_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/imem_array.sv
// Instruction word storage: one synchronous write port, one asynchronous read port.
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = IMEM_AW,
  parameter int DW    = IMEM_DW
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // No reset: program contents survive a server reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_server.sv
// Single-outstanding instruction fetch server with fixed response latency
// and a program-load write port that has priority over fetch acceptance.
module imem_server
  import imem_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int DEPTH   = IMEM_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [31:0]        req_addr,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [31:0]        resp_data,
  output logic               resp_err,
  input  logic               load_valid,
  input  logic [IMEM_AW-1:0] load_addr,
  input  logic [IMEM_DW-1:0] load_data
);

  localparam logic [IMEM_CW-1:0] CNT_INIT = IMEM_CW'(LATENCY - 1);
  localparam logic [IMEM_CW-1:0] CNT_ONE  = IMEM_CW'(1);

  state_e             state_q, state_d;
  logic [IMEM_CW-1:0] cnt_q, cnt_d;
  logic [31:0]        data_q, data_d;
  logic               err_q, err_d;
  logic [31:0]        rd_data;
  logic               addr_bad;

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (IMEM_AW),
    .DW    (IMEM_DW)
  ) u_array (
    .clk     (clk),
    .we_i    (load_valid & ~reset),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .raddr_i (req_addr[7:2]),
    .rdata_o (rd_data)
  );

  assign addr_bad = (req_addr[1:0] != 2'b00) || (req_addr[31:8] != 24'h0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        // A program load in the same cycle always wins over a fetch.
        req_ready = ~load_valid;
        if (req_valid && !load_valid) begin
          data_d = addr_bad ? 32'h0 : rd_data;
          err_d  = addr_bad;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_ONE) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign resp_data = data_q;
  assign resp_err  = err_q;

endmodule

// File: tb/tb_imem_server.sv
// Randomized scoreboard bench for imem_server against a transaction-level model.
module tb_imem_server;

  localparam int LAT = 2;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        load_valid;
  logic [5:0]  load_addr;
  logic [31:0] load_data;

  imem_server #(.LATENCY(LAT), .DEPTH(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .load_valid (load_valid),
    .load_addr  (load_addr),
    .load_data  (load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_mem [64];
  bit          busy;
  int          due;
  int          cyc;
  int          n_tests;
  int          n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding fetch, response due LAT edges after acceptance.
  task automatic model_step();
    bit          exp_ready;
    bit          exp_rvalid;
    bit          bad;
    exp_t        e;
    exp_ready  = !busy && !load_valid;
    exp_rvalid = busy && (cyc >= due);
    chk("req_ready", {31'h0, req_ready}, {31'h0, exp_ready});
    chk("resp_valid", {31'h0, resp_valid}, {31'h0, exp_rvalid});
    if (exp_rvalid && resp_ready) busy = 1'b0;
    if (req_valid && exp_ready) begin
      bad    = (req_addr[1:0] != 2'b00) || (req_addr > 32'hFF);
      e.err  = bad;
      e.data = bad ? 32'h0 : model_mem[req_addr[7:2]];
      sb_q.push_back(e);
      busy = 1'b1;
      due  = cyc + LAT;
    end
    if (load_valid) model_mem[load_addr] = load_data;
  endtask

  task automatic cycle(input logic rv, input logic [31:0] ra, input logic lv,
                       input logic [5:0] la, input logic [31:0] ld, input logic rr);
    @(posedge clk);
    cyc++;
    #1;
    req_valid  = rv;
    req_addr   = ra;
    load_valid = lv;
    load_addr  = la;
    load_data  = ld;
    resp_ready = rr;
    @(negedge clk);
    model_step();
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned sel;
    logic [31:0] a;
    sel = $urandom_range(0, 9);
    a   = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
    if (sel == 8) a[1:0] = 2'($urandom_range(1, 3));
    else if (sel == 9) a[31:8] = 24'($urandom_range(1, 32'h00FF_FFFF));
    return a;
  endfunction

  // Monitor: compares every presented response against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      if (sb_q.size() == 0) begin
        chk("resp_unexpected", {31'h0, resp_valid}, 32'h0);
      end else begin
        chk("resp_data", resp_data, sb_q[0].data);
        chk("resp_err", {31'h0, resp_err}, {31'h0, sb_q[0].err});
        if (resp_ready) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; busy = 1'b0; due = 0;
    for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
    reset = 1'b1; req_valid = 1'b0; req_addr = 32'h0; resp_ready = 1'b0;
    load_valid = 1'b0; load_addr = 6'h0; load_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 64; i++)
      cycle(1'b0, 32'h0, 1'b1, 6'(i), (i == 5) ? 32'h2002000A : $urandom, 1'b0);

    // Basic fetch, then misaligned and out-of-range fetches.
    cycle(1'b1, 32'h14, 1'b0, 6'h0, 32'h0, 1'b1);
    repeat (4) cycle(1'b0, 32'h0, 1'b0, 6'h0, 32'h0, 1'b1);
    cycle(1'b1, 32'h16, 1'b0, 6'h0, 32'h0, 1'b1);
    repeat (3) cycle(1'b0, 32'h0, 1'b0, 6'h0, 32'h0, 1'b1);
    cycle(1'b1, 32'h100, 1'b0, 6'h0, 32'h0, 1'b1);
    repeat (3) cycle(1'b0, 32'h0, 1'b0, 6'h0, 32'h0, 1'b1);

    // Stalled response with a second request held pending.
    cycle(1'b1, 32'h20, 1'b0, 6'h0, 32'h0, 1'b0);
    repeat (7) cycle(1'b1, 32'h24, 1'b0, 6'h0, 32'h0, 1'b0);
    cycle(1'b1, 32'h24, 1'b0, 6'h0, 32'h0, 1'b1);
    repeat (5) cycle(1'b0, 32'h0, 1'b0, 6'h0, 32'h0, 1'b1);

    // Load during WAIT must not disturb the in-flight word.
    cycle(1'b0, 32'h0, 1'b1, 6'd5, 32'hA, 1'b0);
    cycle(1'b1, 32'h14, 1'b0, 6'h0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 6'd5, 32'hB, 1'b1);
    repeat (3) cycle(1'b0, 32'h0, 1'b0, 6'h0, 32'h0, 1'b1);
    cycle(1'b1, 32'h14, 1'b0, 6'h0, 32'h0, 1'b1);
    repeat (3) cycle(1'b0, 32'h0, 1'b0, 6'h0, 32'h0, 1'b1);

    // Loads block acceptance while a request is held.
    repeat (3) cycle(1'b1, 32'h8, 1'b1, 6'd7, $urandom, 1'b1);
    cycle(1'b1, 32'h8, 1'b0, 6'h0, 32'h0, 1'b1);
    repeat (3) cycle(1'b0, 32'h0, 1'b0, 6'h0, 32'h0, 1'b1);

    for (int i = 0; i < 500; i++)
      cycle($urandom_range(0, 99) < 60, rand_addr(), $urandom_range(0, 99) < 20,
            6'($urandom_range(0, 63)), $urandom, $urandom_range(0, 99) < 60);
    repeat (6) cycle(1'b0, 32'h0, 1'b0, 6'h0, 32'h0, 1'b1);

    // Asynchronous reset in the middle of WAIT.
    cycle(1'b1, 32'h14, 1'b0, 6'h0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 6'h0, 32'h0, 1'b1);
    #1;
    reset      = 1'b1;
    load_valid = 1'b1;
    load_addr  = 6'd5;
    load_data  = 32'hDEADBEEF;
    busy       = 1'b0;
    sb_q.delete();
    #1;
    chk("arst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("arst_resp_data", resp_data, 32'h0);
    chk("arst_resp_err", {31'h0, resp_err}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset      = 1'b0;
    load_valid = 1'b0;
    repeat (6) cycle(1'b0, 32'h0, 1'b0, 6'h0, 32'h0, 1'b1);
    cycle(1'b1, 32'h14, 1'b0, 6'h0, 32'h0, 1'b1);
    repeat (4) cycle(1'b0, 32'h0, 1'b0, 6'h0, 32'h0, 1'b1);
    chk("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
